// File: rtl/horizontal_tf_gen_pkg.sv
// -----------------------------------------------------------------------------
// htf_pkg
// Shared types and default constants for the horizontal twiddle-factor
// generator (horizontal_tf_gen) and its table RAM.
//   state_t      : generator FSM state (IDLE, RUN)
//   DEF_*        : default parameter values used by the interface and modules
//   IDX_W        : table index width for the default table depth
// -----------------------------------------------------------------------------
package htf_pkg;

   localparam int DEF_P_WIDTH      = 64;
   localparam int DEF_DEPTH        = 64;
   localparam int DEF_SC_WIDTH     = 3;
   localparam int DEF_ACTIVE_STAGE = 0;
   localparam int DEF_IDX_START    = 1;
   localparam int DEF_RPT_WIDTH    = 4;

   localparam int IDX_W = $clog2(DEF_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/horizontal_tf_gen_if.sv
// -----------------------------------------------------------------------------
// horizontal_tf_gen_if
// Bundles the control, table-write and twiddle-output signals of the
// horizontal twiddle-factor generator.
//   master : driven by the butterfly-row controller (or a testbench)
//   slave  : the generator itself
// Control : CEN (active low), stage_counter, start, stop, repeat_m1
// Write   : wr_en, wr_addr, wr_data (table load, accepted at any time)
// Output  : Q, Q_valid, idx_out, wrap, dbg_state (FSM state for observation)
// Optional (HTF_UNINIT_CHK_EN): err_uninit, sticky uninitialised-read flag.
//
// Handshake: there is no backpressure. A factor is produced one cycle after a
// qualifying edge and is consumed on the cycle Q_valid is high; Q and idx_out
// hold their last value while Q_valid is low.
// -----------------------------------------------------------------------------
interface horizontal_tf_gen_if #(
   parameter int P_WIDTH   = htf_pkg::DEF_P_WIDTH,
   parameter int DEPTH     = htf_pkg::DEF_DEPTH,
   parameter int SC_WIDTH  = htf_pkg::DEF_SC_WIDTH,
   parameter int RPT_WIDTH = htf_pkg::DEF_RPT_WIDTH
);
   import htf_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic                 CEN;
   logic [SC_WIDTH-1:0]  stage_counter;
   logic                 start;
   logic                 stop;
   logic [RPT_WIDTH-1:0] repeat_m1;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [P_WIDTH-1:0]   wr_data;
   logic [P_WIDTH-1:0]   Q;
   logic                 Q_valid;
   logic [AW-1:0]        idx_out;
   logic                 wrap;
   state_t               dbg_state;
`ifdef HTF_UNINIT_CHK_EN
   logic                 err_uninit;
`endif

   modport master (
      output CEN, stage_counter, start, stop, repeat_m1,
      output wr_en, wr_addr, wr_data,
      input  Q, Q_valid, idx_out, wrap, dbg_state
`ifdef HTF_UNINIT_CHK_EN
      , input err_uninit
`endif
   );

   modport slave (
      input  CEN, stage_counter, start, stop, repeat_m1,
      input  wr_en, wr_addr, wr_data,
      output Q, Q_valid, idx_out, wrap, dbg_state
`ifdef HTF_UNINIT_CHK_EN
      , output err_uninit
`endif
   );

endinterface

// File: rtl/horizontal_tf_gen_table_ram.sv
// -----------------------------------------------------------------------------
// htf_table_ram
// DEPTH x P_WIDTH twiddle table: one write port, one registered read port.
// Read-first: a read and a write to the same address in one cycle return the
// old word. The array is never reset; only the read register is cleared so the
// generator output starts at zero.
//   clk, rst   : clock, synchronous active-high reset (read register only)
//   we_i       : write strobe, honoured even while rst is high
//   waddr_i    : write address
//   wdata_i    : write data
//   re_i       : read enable; rdata_o holds when low
//   raddr_i    : read address
//   rdata_o    : registered read data
// -----------------------------------------------------------------------------
module htf_table_ram
   import htf_pkg::*;
#(
   parameter int P_WIDTH = DEF_P_WIDTH,
   parameter int DEPTH   = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [P_WIDTH-1:0]       wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [P_WIDTH-1:0]       rdata_o
);

   logic [P_WIDTH-1:0] mem_q [DEPTH];
   logic [P_WIDTH-1:0] rdata_q;

   // Table storage: no reset so contents survive rst, and writes land even
   // while rst is asserted.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Non-blocking read of the array gives the pre-write word on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/horizontal_tf_gen.sv
// -----------------------------------------------------------------------------
// horizontal_tf_gen
// Run-time-loadable horizontal twiddle-factor generator for one radix-16
// butterfly row. Streams table[idx] on every qualifying cycle and advances idx
// every (repeat_m1+1) outputs, wrapping modulo DEPTH.
//   clk : clock
//   rst : synchronous active-high reset, priority over every other input
//   bus : horizontal_tf_gen_if.slave (control, table write, outputs, dbg_state)
// Optional feature macro: HTF_UNINIT_CHK_EN adds a per-entry written mask and
// the sticky err_uninit output on the interface.
// -----------------------------------------------------------------------------
module horizontal_tf_gen
   import htf_pkg::*;
#(
   parameter int P_WIDTH      = DEF_P_WIDTH,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int SC_WIDTH     = DEF_SC_WIDTH,
   parameter int ACTIVE_STAGE = DEF_ACTIVE_STAGE,
   parameter int IDX_START    = DEF_IDX_START,
   parameter int RPT_WIDTH    = DEF_RPT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   horizontal_tf_gen_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);

   state_t               state_q, state_d;
   logic [RPT_WIDTH-1:0] cnt_q, cnt_d;
   logic [RPT_WIDTH-1:0] rpt_q, rpt_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [AW-1:0]        idx_out_q, idx_out_d;
   logic                 valid_q, valid_d;
   logic                 wrap_q, wrap_d;
   logic                 qual;
   logic [P_WIDTH-1:0]   rdata;

   // A factor is produced only when running, enabled, on our stage, and not
   // being started or stopped in the same cycle.
   assign qual = (state_q == RUN) && !bus.CEN &&
                 (bus.stage_counter == SC_WIDTH'(ACTIVE_STAGE)) &&
                 !bus.start && !bus.stop;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rpt_d     = rpt_q;
      idx_d     = idx_q;
      idx_out_d = idx_out_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
               idx_d   = AW'(IDX_START);
               rpt_d   = bus.repeat_m1;
            end
         end
         RUN: begin
            // start beats stop, so a simultaneous pair restarts the stream.
            if (bus.start) begin
               cnt_d = '0;
               idx_d = AW'(IDX_START);
               rpt_d = bus.repeat_m1;
            end else if (bus.stop) begin
               state_d = IDLE;
            end else if (qual) begin
               idx_out_d = idx_q;
               valid_d   = 1'b1;
               if (cnt_q == rpt_q) begin
                  cnt_d  = '0;
                  idx_d  = idx_q + 1'b1;
                  wrap_d = (idx_q == AW'(DEPTH - 1));
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rpt_q     <= '0;
         idx_q     <= AW'(IDX_START);
         idx_out_q <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rpt_q     <= rpt_d;
         idx_q     <= idx_d;
         idx_out_q <= idx_out_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
      end
   end

   htf_table_ram #(
      .P_WIDTH (P_WIDTH),
      .DEPTH   (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bus.wr_en),
      .waddr_i (bus.wr_addr),
      .wdata_i (bus.wr_data),
      .re_i    (qual),
      .raddr_i (idx_q),
      .rdata_o (rdata)
   );

   assign bus.Q         = rdata;
   assign bus.Q_valid   = valid_q;
   assign bus.idx_out   = idx_out_q;
   assign bus.wrap      = wrap_q;
   assign bus.dbg_state = state_q;

`ifdef HTF_UNINIT_CHK_EN
   logic [DEPTH-1:0] mask_q;
   logic             err_q;

   // rst wins over a concurrent write, so the mask starts clean even though
   // the table itself accepts that write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (bus.wr_en) begin
            mask_q[bus.wr_addr] <= 1'b1;
         end
         if (qual && !mask_q[idx_q]) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err_uninit = err_q;
`endif

endmodule

// File: tb/tb_horizontal_tf_gen.sv
// -----------------------------------------------------------------------------
// tb_horizontal_tf_gen
// Self-checking bench for horizontal_tf_gen (default parameters).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_horizontal_tf_gen;
  import htf_pkg::*;

  localparam int P_W   = 64;
  localparam int DEPTH = 64;
  localparam int IW    = IDX_W;
  localparam int SCW   = 3;
  localparam int RW    = 4;
  localparam int EXP_W = P_W + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  horizontal_tf_gen_if #(.P_WIDTH(P_W), .DEPTH(DEPTH), .SC_WIDTH(SCW), .RPT_WIDTH(RW)) bus ();

  horizontal_tf_gen #(
    .P_WIDTH(P_W), .DEPTH(DEPTH), .SC_WIDTH(SCW),
    .ACTIVE_STAGE(0), .IDX_START(1), .RPT_WIDTH(RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];

  // reference model of the generator
  logic [P_W-1:0] m_tab [DEPTH];
  logic           m_run;
  logic [RW-1:0]  m_cnt;
  logic [RW-1:0]  m_rpt;
  logic [IW-1:0]  m_idx;
  logic [P_W-1:0] m_q;
  logic [IW-1:0]  m_io;
  logic [DEPTH-1:0] m_mask;
  logic           m_err;

  task automatic check(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = '0;
    m_rpt  = '0;
    m_idx  = IW'(1);
    m_q    = '0;
    m_io   = '0;
    m_mask = '0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.CEN = 1'b1; bus.stage_counter = '0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.repeat_m1 = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic cen, input logic [SCW-1:0] sc, input logic st, input logic sp,
                      input logic [RW-1:0] rpt, input logic we, input logic [IW-1:0] wa,
                      input logic [P_W-1:0] wd);
    logic qual;
    logic [EXP_W-1:0] e;
    bus.CEN = cen; bus.stage_counter = sc; bus.start = st; bus.stop = sp;
    bus.repeat_m1 = rpt; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    qual = m_run && !cen && (sc == '0) && !st && !sp;
    if (qual) begin
      exp_q.push_back({m_tab[m_idx], m_idx, (m_cnt == m_rpt) && (m_idx == IW'(DEPTH - 1))});
      if (!m_mask[m_idx]) m_err = 1'b1;
    end
    if (st) begin
      m_run = 1'b1; m_cnt = '0; m_idx = IW'(1); m_rpt = rpt;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (qual) begin
      if (m_cnt == m_rpt) begin
        m_cnt = '0;
        m_idx = m_idx + 1'b1;
      end else begin
        m_cnt = m_cnt + 1'b1;
      end
    end
    // table write lands after the read: old word was already captured above
    if (we) begin
      m_tab[wa] = wd;
      m_mask[wa] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("Q_valid", P_W'(bus.Q_valid), P_W'(qual));
    check("state", P_W'(bus.dbg_state), P_W'(m_run));
`ifdef HTF_UNINIT_CHK_EN
    check("err_uninit", P_W'(bus.err_uninit), P_W'(m_err));
`endif
    if (qual) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("Q", bus.Q, e[EXP_W-1 -: P_W]);
        check("idx_out", P_W'(bus.idx_out), P_W'(e[IW:1]));
        check("wrap", P_W'(bus.wrap), P_W'(e[0]));
        m_q  = e[EXP_W-1 -: P_W];
        m_io = e[IW:1];
      end
    end else begin
      check("Q_hold", bus.Q, m_q);
      check("idx_out_hold", P_W'(bus.idx_out), P_W'(m_io));
      check("wrap_idle", P_W'(bus.wrap), 64'd0);
    end
  endtask

  task automatic q_step();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic start_step(input logic [RW-1:0] rpt);
    step(1'b0, '0, 1'b1, 1'b0, rpt, 1'b0, '0, '0);
  endtask

  task automatic reset_and_check();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst.Q", bus.Q, 64'd0);
    check("rst.Q_valid", P_W'(bus.Q_valid), 64'd0);
    check("rst.idx_out", P_W'(bus.idx_out), 64'd0);
    check("rst.wrap", P_W'(bus.wrap), 64'd0);
    check("rst.state", P_W'(bus.dbg_state), P_W'(IDLE));
`ifdef HTF_UNINIT_CHK_EN
    check("rst.err_uninit", P_W'(bus.err_uninit), 64'd0);
`endif
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic           cen;
    logic [SCW-1:0] sc;
    logic           st;
    logic           sp;
    logic [RW-1:0]  rpt;
    logic           ev;
    logic [P_W-1:0] eq;
    logic [IW-1:0]  ei;
    logic           ew;
    logic           erun;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic cen, input logic [SCW-1:0] sc, input logic st,
                              input logic sp, input logic [RW-1:0] rpt, input logic ev,
                              input logic [P_W-1:0] eq, input logic [IW-1:0] ei,
                              input logic ew, input logic erun);
    vec_t v;
    v.cen = cen; v.sc = sc; v.st = st; v.sp = sp; v.rpt = rpt;
    v.ev = ev; v.eq = eq; v.ei = ei; v.ew = ew; v.erun = erun;
    return v;
  endfunction

  // watchdog: the bench contains no open-ended waits, this only guards a hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();

    // Load the table while rst is held: writes must still land.
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = IW'(i); bus.wr_data = P_W'(64'h1000 + i);
      m_tab[i] = P_W'(64'h1000 + i);
      @(posedge clk);
      @(negedge clk);
    end
    reset_and_check();

    // Directed vectors right after reset (Q starts at 0), repeat_m1=1.
    vecs[0]  = mk(0, 0, 1, 0, 1, 0, 64'h0,    0, 0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 64'h1001, 1, 0, 1);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 64'h1001, 1, 0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 64'h1001, 1, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 64'h1001, 1, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 64'h1002, 2, 0, 1);
    vecs[6]  = mk(0, 0, 1, 1, 0, 0, 64'h1002, 2, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 64'h1001, 1, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 64'h1002, 2, 0, 1);
    vecs[9]  = mk(0, 0, 0, 1, 0, 0, 64'h1002, 2, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 64'h1002, 2, 0, 0);
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 64'h1002, 2, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 64'h1001, 1, 0, 1);
    for (int i = 0; i < 13; i++) begin
      bus.CEN = vecs[i].cen; bus.stage_counter = vecs[i].sc;
      bus.start = vecs[i].st; bus.stop = vecs[i].sp; bus.repeat_m1 = vecs[i].rpt;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.Q_valid", i), P_W'(bus.Q_valid), P_W'(vecs[i].ev));
      check($sformatf("vec%0d.Q", i), bus.Q, vecs[i].eq);
      check($sformatf("vec%0d.idx_out", i), P_W'(bus.idx_out), P_W'(vecs[i].ei));
      check($sformatf("vec%0d.wrap", i), P_W'(bus.wrap), P_W'(vecs[i].ew));
      check($sformatf("vec%0d.state", i), P_W'(bus.dbg_state), P_W'(vecs[i].erun));
    end

    // Scoreboard phase from a clean reset.
    reset_and_check();

    // repeat_m1=15: sixteen 0x1001 then 0x1002 ...
    start_step(4'd15);
    for (int i = 0; i < 40; i++) q_step();

    // CEN gap at cnt=7
    start_step(4'd15);
    for (int i = 0; i < 7; i++) q_step();
    for (int i = 0; i < 5; i++) step(1'b1, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 12; i++) q_step();

    // repeat_m1=0: full sweep with wrap on idx 63
    start_step(4'd0);
    for (int i = 0; i < 65; i++) q_step();

    // off-stage cycles freeze the stream; start+stop restarts
    for (int i = 0; i < 4; i++) step(1'b0, 3'd1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 1'b1, 4'd0, 1'b0, '0, '0);
    q_step();

    // read-first collision on idx 5, then read back after restart
    start_step(4'd0);
    for (int i = 0; i < 4; i++) q_step();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, IW'(5), 64'hDEAD);
    start_step(4'd0);
    for (int i = 0; i < 5; i++) q_step();

    // reset mid-RUN keeps the table
    start_step(4'd2);
    for (int i = 0; i < 3; i++) q_step();
    reset_and_check();
    start_step(4'd0);
    for (int i = 0; i < 6; i++) q_step();

    // constrained-random mix
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0) ? SCW'($urandom_range(1, 7)) : '0,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0), RW'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), IW'($urandom_range(0, DEPTH - 1)),
           {$urandom, $urandom});
    end

`ifdef HTF_UNINIT_CHK_EN
    // only entries 0..3 written since reset: the idx 4 read raises err_uninit
    reset_and_check();
    for (int i = 0; i < 4; i++) step(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, IW'(i), P_W'(64'h2000 + i));
    start_step(4'd0);
    for (int i = 0; i < 8; i++) q_step();
    check("err_uninit_sticky", P_W'(bus.err_uninit), 64'd1);
    reset_and_check();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
